// File: rtl/sb_pkg.sv
// Shared types and sizing for the store buffer: default depth, pointer width
// and the buffered-store entry layout.
package sb_pkg;

  localparam int SB_DEPTH = 4;
  localparam int SB_PTR_W = $clog2(SB_DEPTH);

  // Word address only; the byte offset is implicit zero.
  typedef struct packed {
    logic [29:0] addr;
    logic [31:0] data;
  } sb_entry_t;

endpackage

// File: rtl/sb_match.sv
// Youngest-first search over the live entries of the store buffer: walks from
// tail-1 back towards head (with pointer wrap) and reports the first match.
module sb_match
  import sb_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0] match,
  input  logic [PTR_W-1:0] tail,
  input  logic [PTR_W:0]   count,
  output logic             hit,
  output logic [PTR_W-1:0] idx
);

  logic [PTR_W-1:0] pos;

  // Age k=0 is the youngest entry; only the first count ages are live.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    pos = '0;
    for (int k = 0; k < DEPTH; k++) begin
      pos = tail - PTR_W'(k + 1);
      if (!hit && ((PTR_W+1)'(k) < count) && match[pos]) begin
        hit = 1'b1;
        idx = pos;
      end
    end
  end

endmodule

// File: rtl/store_buffer.sv
// Circular store buffer between the core's MEM stage and backing memory, with
// youngest-match load forwarding and a sticky overflow flag for dropped stores.
module store_buffer
  import sb_pkg::*;
#(
  parameter int DEPTH = SB_DEPTH
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] cpu_addr,
  input  logic        cpu_read,
  input  logic        cpu_write,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        sb_stall,
  output logic        mem_we,
  output logic [31:0] mem_waddr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  output logic [31:0] mem_raddr,
  input  logic [31:0] mem_rdata,
  output logic        overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [PTR_W-1:0] head_q;
  logic [PTR_W-1:0] tail_q;
  logic [PTR_W:0]   count_q;
  logic             overflow_q;
  sb_entry_t        buf_q [DEPTH];

  logic             full;
  logic             pop;
  logic             enq;
  logic             drop;
  logic [DEPTH-1:0] match;
  logic             hit;
  logic [PTR_W-1:0] hit_idx;
  sb_entry_t        head_entry;
  logic             unused_addr_bits;

  // Handshake: mem_we/mem_ready form a valid/ready pair. A drain transfers on
  // any cycle where both are high; until then the head entry (mem_waddr,
  // mem_wdata) is held stable. mem_we never depends on mem_ready.
  assign full       = (count_q == FULL_CNT);
  assign head_entry = buf_q[head_q];

  // Outputs are forced idle while RST is high so nothing stale leaks out
  // during the reset cycle itself.
  assign mem_we    = (count_q != '0) && !RST;
  assign sb_stall  = full && !RST;
  assign overflow  = overflow_q && !RST;
  assign mem_waddr = {head_entry.addr, 2'b00};
  assign mem_wdata = head_entry.data;
  assign mem_raddr = {cpu_addr[31:2], 2'b00};

  assign pop  = mem_we && mem_ready;
  assign enq  = cpu_write && (!full || pop);
  assign drop = cpu_write && full && !pop;

  assign unused_addr_bits = ^cpu_addr[1:0];

  // Registered state only, so a same-cycle store is never a forwarding source
  // while a same-cycle pop still is.
  always_comb begin
    match = '0;
    for (int i = 0; i < DEPTH; i++) begin
      match[i] = (buf_q[i].addr == cpu_addr[31:2]);
    end
  end

  sb_match #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_match (
    .match (match),
    .tail  (tail_q),
    .count (count_q),
    .hit   (hit),
    .idx   (hit_idx)
  );

  assign cpu_rdata = (cpu_read && hit && !RST) ? buf_q[hit_idx].data : mem_rdata;

  always_ff @(posedge CLK) begin
    if (RST) begin
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (pop) begin
        head_q <= head_q + 1'b1;
      end
      if (enq) begin
        tail_q <= tail_q + 1'b1;
      end
      if (enq && !pop) begin
        count_q <= count_q + 1'b1;
      end else if (pop && !enq) begin
        count_q <= count_q - 1'b1;
      end
      if (drop) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // Entry storage carries no reset; liveness comes from head/count alone.
  always_ff @(posedge CLK) begin
    if (enq && !RST) begin
      buf_q[tail_q] <= '{addr: cpu_addr[31:2], data: cpu_wdata};
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Bench for store_buffer: directed scenarios then random traffic, checked
// against a queue-based model of the buffer contents.
module tb_store_buffer;

  localparam int DEPTH = 4;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] cpu_addr;
  logic        cpu_read;
  logic        cpu_write;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        sb_stall;
  logic        mem_we;
  logic [31:0] mem_waddr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_raddr;
  logic [31:0] mem_rdata;
  logic        overflow;

  // Expected contents, oldest first: {word-aligned address, data}.
  logic [63:0] exp_q[$];
  logic        exp_ovf;
  int          checks;
  int          errors;

  store_buffer #(.DEPTH(DEPTH)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .cpu_addr  (cpu_addr),
    .cpu_read  (cpu_read),
    .cpu_write (cpu_write),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .sb_stall  (sb_stall),
    .mem_we    (mem_we),
    .mem_waddr (mem_waddr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .mem_raddr (mem_raddr),
    .mem_rdata (mem_rdata),
    .overflow  (overflow)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, check outputs mid-cycle, then advance the model.
  task automatic step(input logic rd, input logic wr, input logic [31:0] a,
                      input logic [31:0] wd, input logic rdy,
                      input logic [31:0] mrd, input logic rst);
    int          n;
    logic [31:0] e_rdata;
    logic        found;
    logic        mpop;
    RST       = rst;
    cpu_read  = rd;
    cpu_write = wr;
    cpu_addr  = a;
    cpu_wdata = wd;
    mem_ready = rdy;
    mem_rdata = mrd;
    #4;
    n = exp_q.size();
    chk("mem_raddr", mem_raddr, {a[31:2], 2'b00});
    if (rst) begin
      chk("rst_mem_we", 32'(mem_we), 32'd0);
      chk("rst_stall", 32'(sb_stall), 32'd0);
      chk("rst_overflow", 32'(overflow), 32'd0);
      chk("rst_rdata", cpu_rdata, mrd);
    end else begin
      chk("mem_we", 32'(mem_we), 32'(n != 0));
      if (n != 0) begin
        chk("mem_waddr", mem_waddr, exp_q[0][63:32]);
        chk("mem_wdata", mem_wdata, exp_q[0][31:0]);
      end
      chk("sb_stall", 32'(sb_stall), 32'(n == DEPTH));
      chk("overflow", 32'(overflow), 32'(exp_ovf));
      e_rdata = mrd;
      found   = 1'b0;
      if (rd) begin
        for (int i = n - 1; i >= 0; i--) begin
          if (!found && exp_q[i][63:34] == a[31:2]) begin
            e_rdata = exp_q[i][31:0];
            found   = 1'b1;
          end
        end
      end
      chk("cpu_rdata", cpu_rdata, e_rdata);
    end
    @(posedge CLK);
    if (rst) begin
      exp_q.delete();
      exp_ovf = 1'b0;
    end else begin
      mpop = (n != 0) && rdy;
      if (mpop) void'(exp_q.pop_front());
      if (wr) begin
        if (n < DEPTH || mpop) exp_q.push_back({a[31:2], 2'b00, wd});
        else exp_ovf = 1'b1;
      end
    end
    #1;
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 1'b0, 32'h0, 32'h0, rdy, 32'h0, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h1234, 1'b1);
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    exp_ovf = 1'b0;
    RST = 1'b1; cpu_read = 0; cpu_write = 0; cpu_addr = 0; cpu_wdata = 0;
    mem_ready = 0; mem_rdata = 0;
    @(posedge CLK); #1;
    do_reset();
    do_reset();
    idle(1'b0);

    // Single store is visible on the drain port next cycle and forwards.
    step(1'b0, 1'b1, 32'h100, 32'hDEADBEEF, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b0, 32'h100, 32'h0, 1'b0, 32'h0, 1'b0);
    chk("fwd_100", cpu_rdata, 32'hDEADBEEF);
    idle(1'b1);
    idle(1'b0);

    // Youngest of two same-word stores wins; neighbour word goes to memory.
    step(1'b0, 1'b1, 32'h200, 32'd1, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b1, 32'h200, 32'd2, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b0, 32'h202, 32'h0, 1'b0, 32'h55, 1'b0);
    step(1'b1, 1'b0, 32'h204, 32'h0, 1'b0, 32'h77, 1'b0);
    for (int i = 0; i < 3; i++) idle(1'b1);

    // Fill, overflow on a dropped store, then accept at full alongside a pop.
    for (int i = 0; i < 4; i++)
      step(1'b0, 1'b1, 32'h300 + 32'(4 * i), 32'hA0 + 32'(i), 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b1, 32'h340, 32'hBAD, 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b1, 32'h344, 32'hC0, 1'b1, 32'h0, 1'b0);
    idle(1'b0);
    chk("full_stall", 32'(sb_stall), 32'd1);
    for (int i = 0; i < 5; i++) idle(1'b1);
    do_reset();

    // Streaming drain through several pointer wraps.
    for (int i = 0; i < 10; i++)
      step(1'b0, 1'b1, 32'(4 * i), 32'h1000 + 32'(i), 1'b1, 32'h0, 1'b0);
    idle(1'b1);
    idle(1'b1);

    // Reset mid-drain discards everything, forwarding included.
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b1, 32'h500 + 32'(4 * i), 32'hE0 + 32'(i), 1'b0, 32'h0, 1'b0);
    step(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 32'h0, 1'b1);
    step(1'b1, 1'b0, 32'h504, 32'h0, 1'b0, 32'hCAFE, 1'b0);

    // Popped head still forwards in its pop cycle.
    step(1'b0, 1'b1, 32'h40, 32'hAB, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b0, 32'h40, 32'h0, 1'b1, 32'h0, 1'b0);
    idle(1'b0);
    chk("empty_after_pop", 32'(mem_we), 32'd0);

    // Random traffic over a small address window to force aliasing.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) != 0),
           {24'h0, 3'($urandom_range(0, 7)), 3'b0, 2'($urandom_range(0, 3))},
           $urandom, 1'($urandom_range(0, 2) == 0), $urandom,
           1'($urandom_range(0, 60) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
